// File: rtl/prim_fp_align_24bit_if.sv
`default_nettype none
// ============================================================================
// Module   : prim_fp_align_24bit_if
// Brief    : Operand/result handshake bundle for the 24-bit FP aligner.
// Revision : 1.0 - initial release
// ============================================================================
interface prim_fp_align_24bit_if;
  logic        i_valid;
  logic        o_ready;
  logic [7:0]  i_exp_a;
  logic [7:0]  i_exp_b;
  logic [23:0] i_man_a;
  logic [23:0] i_man_b;
  logic        i_man_eq;
  logic        i_man_gt;
  logic        i_man_lt;
  logic        o_valid;
  logic        i_ready;
  logic [7:0]  o_exp_big;
  logic [23:0] o_man_big;
  logic [26:0] o_man_small;
  logic [7:0]  o_exp_diff;
  logic        o_swap;
  logic        o_ops_equal;

  modport slave (
    input  i_valid, i_exp_a, i_exp_b, i_man_a, i_man_b,
           i_man_eq, i_man_gt, i_man_lt, i_ready,
    output o_ready, o_valid, o_exp_big, o_man_big, o_man_small,
           o_exp_diff, o_swap, o_ops_equal
  );

  modport master (
    output i_valid, i_exp_a, i_exp_b, i_man_a, i_man_b,
           i_man_eq, i_man_gt, i_man_lt, i_ready,
    input  o_ready, o_valid, o_exp_big, o_man_big, o_man_small,
           o_exp_diff, o_swap, o_ops_equal
  );
endinterface
`default_nettype wire

// File: rtl/prim_fp_align_24bit.sv
`default_nettype none
// ============================================================================
// Module   : prim_fp_align_24bit
// Brief    : Two-stage FP operand aligner: S1 orders operands, S2 shifts + sticky.
// Revision : 1.0 - initial release
// ============================================================================
module prim_fp_align_24bit (
  input  logic                        i_clk,
  input  logic                        i_rst,
  prim_fp_align_24bit_if.slave        bus
);
  localparam int unsigned C_EXT_W     = 27;
  localparam logic [7:0]  C_SHIFT_SAT = 8'd27;

  logic w_s1_adv;
  logic w_s2_adv;
  logic w_accept;
  logic r_s1_valid;
  logic r_s2_valid;

  assign w_s2_adv    = ~r_s2_valid | bus.i_ready;
  assign w_s1_adv    = ~r_s1_valid | w_s2_adv;
  assign w_accept    = bus.i_valid & w_s1_adv;
  assign bus.o_ready = w_s1_adv;

  // The magnitude order is fully determined by the exponents and i_man_lt/eq.
  logic w_unused_gt;
  assign w_unused_gt = bus.i_man_gt;

  logic       w_exp_a_gt;
  logic       w_exp_eq;
  logic       w_ops_eq;
  logic       w_a_big;
  logic [7:0] w_exp_diff;

  assign w_exp_a_gt = bus.i_exp_a > bus.i_exp_b;
  assign w_exp_eq   = bus.i_exp_a == bus.i_exp_b;
  assign w_ops_eq   = w_exp_eq & bus.i_man_eq;
  assign w_a_big    = w_exp_a_gt | (w_exp_eq & (~bus.i_man_lt | bus.i_man_eq));
  assign w_exp_diff = w_a_big ? (bus.i_exp_a - bus.i_exp_b) : (bus.i_exp_b - bus.i_exp_a);

  logic [7:0]  r_s1_exp_big;
  logic [23:0] r_s1_man_big;
  logic [23:0] r_s1_man_small;
  logic [7:0]  r_s1_exp_diff;
  logic        r_s1_swap;
  logic        r_s1_ops_eq;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid     <= 1'b0;
      r_s1_exp_big   <= '0;
      r_s1_man_big   <= '0;
      r_s1_man_small <= '0;
      r_s1_exp_diff  <= '0;
      r_s1_swap      <= 1'b0;
      r_s1_ops_eq    <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= bus.i_valid;
      end
      if (w_accept) begin
        r_s1_exp_big   <= w_a_big ? bus.i_exp_a : bus.i_exp_b;
        r_s1_man_big   <= w_a_big ? bus.i_man_a : bus.i_man_b;
        r_s1_man_small <= w_a_big ? bus.i_man_b : bus.i_man_a;
        r_s1_exp_diff  <= w_exp_diff;
        r_s1_swap      <= ~w_a_big;
        r_s1_ops_eq    <= w_ops_eq;
      end
    end
  end

  logic [26:0] w_ext;
  logic [26:0] w_shifted;
  logic [26:0] w_lost_mask;
  logic [26:0] w_aligned;

  // Bits shifted past the R position are folded into the sticky LSB.
  always_comb begin
    w_ext       = {r_s1_man_small, 3'b000};
    w_shifted   = w_ext >> r_s1_exp_diff[4:0];
    w_lost_mask = ~({C_EXT_W{1'b1}} << r_s1_exp_diff[4:0]);
    if (r_s1_exp_diff >= C_SHIFT_SAT) begin
      w_aligned = {26'b0, |r_s1_man_small};
    end else begin
      w_aligned = {w_shifted[26:1], w_shifted[0] | (|(w_ext & w_lost_mask))};
    end
  end

  logic [7:0]  r_exp_big;
  logic [23:0] r_man_big;
  logic [26:0] r_man_small;
  logic [7:0]  r_exp_diff;
  logic        r_swap;
  logic        r_ops_eq;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s2_valid  <= 1'b0;
      r_exp_big   <= '0;
      r_man_big   <= '0;
      r_man_small <= '0;
      r_exp_diff  <= '0;
      r_swap      <= 1'b0;
      r_ops_eq    <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_exp_big   <= r_s1_exp_big;
        r_man_big   <= r_s1_man_big;
        r_man_small <= w_aligned;
        r_exp_diff  <= r_s1_exp_diff;
        r_swap      <= r_s1_swap;
        r_ops_eq    <= r_s1_ops_eq;
      end
    end
  end

  assign bus.o_valid     = r_s2_valid;
  assign bus.o_exp_big   = r_exp_big;
  assign bus.o_man_big   = r_man_big;
  assign bus.o_man_small = r_man_small;
  assign bus.o_exp_diff  = r_exp_diff;
  assign bus.o_swap      = r_swap;
  assign bus.o_ops_equal = r_ops_eq;
endmodule
`default_nettype wire

// File: tb/tb_prim_fp_align_24bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_prim_fp_align_24bit
// Brief    : Directed self-checking bench for prim_fp_align_24bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prim_fp_align_24bit;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   accepted;

  prim_fp_align_24bit_if bus ();

  prim_fp_align_24bit dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] ea, input logic [23:0] ma,
                       input logic [7:0] eb, input logic [23:0] mb);
    bus.i_valid  = v;
    bus.i_exp_a  = ea;
    bus.i_man_a  = ma;
    bus.i_exp_b  = eb;
    bus.i_man_b  = mb;
    bus.i_man_eq = (ma == mb);
    bus.i_man_gt = (ma > mb);
    bus.i_man_lt = (ma < mb);
  endtask

  task automatic check_out(input string tag, input logic [7:0] eb, input logic [23:0] mb,
                           input logic [26:0] ms, input logic [7:0] ed,
                           input logic sw, input logic eq);
    check({tag, ":valid"},     32'(bus.o_valid),     32'd1);
    check({tag, ":exp_big"},   32'(bus.o_exp_big),   32'(eb));
    check({tag, ":man_big"},   32'(bus.o_man_big),   32'(mb));
    check({tag, ":man_small"}, 32'(bus.o_man_small), 32'(ms));
    check({tag, ":exp_diff"},  32'(bus.o_exp_diff),  32'(ed));
    check({tag, ":swap"},      32'(bus.o_swap),      32'(sw));
    check({tag, ":ops_eq"},    32'(bus.o_ops_equal), 32'(eq));
  endtask

  task automatic run_single(input string tag,
                            input logic [7:0] ea, input logic [23:0] ma,
                            input logic [7:0] eb_in, input logic [23:0] mb_in,
                            input logic [7:0] eb, input logic [23:0] mb,
                            input logic [26:0] ms, input logic [7:0] ed,
                            input logic sw, input logic eq);
    @(negedge clk);
    check({tag, ":ready"}, 32'(bus.o_ready), 32'd1);
    drive(1'b1, ea, ma, eb_in, mb_in);
    @(negedge clk);
    drive(1'b0, 8'h00, 24'h0, 8'h00, 24'h0);
    check({tag, ":early"}, 32'(bus.o_valid), 32'd0);
    @(negedge clk);
    check_out(tag, eb, mb, ms, ed, sw, eq);
  endtask

  // Stream pair k: A exp 0x81+k man 0x800000, B exp 0x80 man 0xC00000.
  logic [26:0] ms_tab [4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    accepted = 0;
    ms_tab[0] = 27'h3000000;
    ms_tab[1] = 27'h1800000;
    ms_tab[2] = 27'h0C00000;
    ms_tab[3] = 27'h0600000;
    rst = 1'b1;
    bus.i_ready = 1'b1;
    drive(1'b0, 8'h00, 24'h0, 8'h00, 24'h0);
    #1;
    check("rst:valid",     32'(bus.o_valid),     32'd0);
    check("rst:man_small", 32'(bus.o_man_small), 32'd0);
    check("rst:exp_big",   32'(bus.o_exp_big),   32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst:ready", 32'(bus.o_ready), 32'd1);

    run_single("basic",  8'h82, 24'hC00000, 8'h80, 24'h800000,
               8'h82, 24'hC00000, 27'h1000000, 8'd2, 1'b0, 1'b0);
    run_single("swap",   8'h81, 24'h800001, 8'h85, 24'hA00000,
               8'h85, 24'hA00000, 27'h0400001, 8'd4, 1'b1, 1'b0);
    run_single("far",    8'h10, 24'h800001, 8'h90, 24'h800000,
               8'h90, 24'h800000, 27'h0000001, 8'h80, 1'b1, 1'b0);
    run_single("equal",  8'h7F, 24'h912345, 8'h7F, 24'h912345,
               8'h7F, 24'h912345, 27'h4891A28, 8'd0, 1'b0, 1'b1);
    run_single("mant_b", 8'h90, 24'h800000, 8'h90, 24'hF00000,
               8'h90, 24'hF00000, 27'h4000000, 8'd0, 1'b1, 1'b0);
    run_single("d25",    8'h99, 24'h800000, 8'h80, 24'h800001,
               8'h99, 24'h800000, 27'h0000003, 8'd25, 1'b0, 1'b0);
    run_single("d27z",   8'h9B, 24'h800000, 8'h80, 24'h000000,
               8'h9B, 24'h800000, 27'h0000000, 8'd27, 1'b0, 1'b0);

    // Back-to-back throughput with the sink always ready.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 2)
        check_out($sformatf("tp%0d", k - 2), 8'(8'h81 + k - 2), 24'h800000,
                  ms_tab[k - 2], 8'(k - 1), 1'b0, 1'b0);
      if (k < 4) drive(1'b1, 8'(8'h81 + k), 24'h800000, 8'h80, 24'hC00000);
      else       drive(1'b0, 8'h00, 24'h0, 8'h00, 24'h0);
    end

    // Stall: sink not ready, source always valid.
    @(negedge clk);
    check("tp:drained", 32'(bus.o_valid), 32'd0);
    bus.i_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("stall%0d:ready", k), 32'(bus.o_ready), 32'(k < 2));
      if (k >= 2) begin
        check($sformatf("stall%0d:valid", k),   32'(bus.o_valid),     32'd1);
        check($sformatf("stall%0d:exp_big", k), 32'(bus.o_exp_big),   32'h81);
        check($sformatf("stall%0d:man_sm", k),  32'(bus.o_man_small), 32'h3000000);
      end
      if (bus.o_ready) accepted++;
      drive(1'b1, 8'(8'h81 + k), 24'h800000, 8'h80, 24'hC00000);
    end
    @(negedge clk);
    check("stall:accepted", 32'(accepted), 32'd2);
    drive(1'b0, 8'h00, 24'h0, 8'h00, 24'h0);
    bus.i_ready = 1'b1;
    check_out("drain0", 8'h81, 24'h800000, 27'h3000000, 8'd1, 1'b0, 1'b0);
    @(negedge clk);
    check_out("drain1", 8'h82, 24'h800000, 27'h1800000, 8'd2, 1'b0, 1'b0);
    @(negedge clk);
    check("drain:nodup", 32'(bus.o_valid), 32'd0);

    // Asynchronous reset with both stages occupied.
    bus.i_ready = 1'b0;
    drive(1'b1, 8'h82, 24'hC00000, 8'h80, 24'h800000);
    @(negedge clk);
    drive(1'b1, 8'h85, 24'hA00000, 8'h81, 24'h800001);
    @(negedge clk);
    drive(1'b0, 8'h00, 24'h0, 8'h00, 24'h0);
    check("arst:pre_valid", 32'(bus.o_valid), 32'd1);
    check("arst:pre_ready", 32'(bus.o_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("arst:valid",   32'(bus.o_valid),   32'd0);
    check("arst:exp_big", 32'(bus.o_exp_big), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.i_ready = 1'b1;
    check("arst:ready", 32'(bus.o_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("arst:stale%0d", k), 32'(bus.o_valid), 32'd0);
    end
    run_single("post", 8'h82, 24'hC00000, 8'h80, 24'h800000,
               8'h82, 24'hC00000, 27'h1000000, 8'd2, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/prim_fp_align_24bit.md
PRIM_FP_ALIGN_24BIT -- requirements
Module: prim_fp_align_24bit

Interface
REQ-001 SHALL have port i_clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port i_valid, input, 1, upstream operand pair valid.
REQ-004 SHALL have port o_ready, output, 1, block can accept an operand pair this cycle.
REQ-005 SHALL have ports i_exp_a and i_exp_b, input, 8 each, biased exponents.
REQ-006 SHALL have ports i_man_a and i_man_b, input, 24 each, mantissas including hidden bit.
REQ-007 SHALL have ports i_man_eq, i_man_gt and i_man_lt, input, 1 each: the unsigned 24-bit magnitude comparison of i_man_a vs i_man_b, same cycle as the operands, with signed mode disabled.
REQ-008 SHALL have port o_valid, output, 1, aligned result valid.
REQ-009 SHALL have port i_ready, input, 1, downstream accepts the result.
REQ-010 SHALL have port o_exp_big, output, 8, exponent of the larger-magnitude operand.
REQ-011 SHALL have port o_man_big, output, 24, mantissa of the larger-magnitude operand.
REQ-012 SHALL have port o_man_small, output, 27, smaller mantissa aligned as {man,G,R,S}.
REQ-013 SHALL have port o_exp_diff, output, 8, exp_big minus exp_small.
REQ-014 SHALL have port o_swap, output, 1; 1 means B was the larger operand.
REQ-015 SHALL have port o_ops_equal, output, 1; exponents and mantissas are identical.

Function
REQ-016 SHALL be a two-stage registered pipeline: S1 does selection and exponent difference, S2 does shift and sticky.
REQ-017 SHALL accept a transfer when i_valid&&o_ready and present its result at o_valid exactly 2 cycles later, provided no stall occurs.
REQ-018 SHALL select A as big when i_exp_a>i_exp_b, or when the exponents are equal and i_man_lt=0; otherwise SHALL select B and set swap=1.
REQ-019 SHALL set ops_equal = (i_exp_a==i_exp_b) & i_man_eq; when equal, SHALL set swap=0.
REQ-020 SHALL compute exp_diff as an unsigned 8-bit value, never negative, because of the ordering in REQ-018.
REQ-021 SHALL extend small mantissa to 27 bits as {man,3'b000}, then shift right logically by exp_diff.
REQ-022 SHALL set bit 0 of o_man_small to the OR of the shifted bit 0 and all bits shifted out (sticky).
REQ-023 SHALL produce o_man_small = {26'b0, |man_small} when exp_diff>=27.
REQ-024 SHALL implement S2 advance as s2_adv = ~s2_valid | i_ready.
REQ-025 SHALL implement S1 advance as s1_adv = ~s1_valid | s2_adv.
REQ-026 SHALL drive o_ready = s1_adv combinationally, with no combinational path from i_valid.
REQ-027 SHALL hold all outputs stable while o_valid=1 and i_ready=0.
REQ-028 SHALL sustain full throughput of 1 pair per cycle when i_ready is held at 1.
REQ-029 SHALL register data only on an accepted transfer; S1 and S2 data are don't-care when their valid is 0.
REQ-030 SHALL ignore the i_man_* flags when i_valid=0.

Reset
REQ-031 SHALL, while i_rst=1, asynchronously clear s1_valid, s2_valid and o_valid to 0, and clear all data registers and outputs to 0.
REQ-032 SHALL, on reset mid-operation, discard in-flight pairs; o_ready SHALL be 1 in the first cycle after reset deassertion.

Verification
REQ-033 SHALL cover: A exp=0x82 man=0xC00000, B exp=0x80 man=0x800000, i_man_gt=1 -> after 2 cycles o_swap=0, o_exp_diff=2, o_exp_big=0x82, o_man_big=0xC00000, o_man_small=0x1000000.
REQ-034 SHALL cover: A exp=0x81 man=0x800001, B exp=0x85 man=0xA00000 -> o_swap=1, o_exp_diff=4, o_man_small=0x400001 (sticky set).
REQ-035 SHALL cover: A exp=0x10 man=0x800001, B exp=0x90 -> o_exp_diff=0x80, o_man_small=0x0000001.
REQ-036 SHALL cover: A and B both exp=0x7F man=0x912345, i_man_eq=1 -> o_ops_equal=1, o_swap=0, o_exp_diff=0, o_man_small=0x4891A28.
REQ-037 SHALL cover: i_valid=1 every cycle with i_ready=0 -> exactly 2 pairs accepted, o_ready=0 from the 3rd cycle, outputs stable; on i_ready=1, results drain in order with no loss or duplication.
REQ-038 SHALL cover: i_rst pulsed with both stages full -> o_valid=0 immediately (asynchronously), no stale result after release, o_ready=1.
